// File: rtl/manchester_tx.sv
// manchester_tx: framed Manchester serializer with preamble, one-word skid buffer and idle trailer
module manchester_tx #(
    parameter int DATA_W        = 8,
    parameter int HALF_BIT_CLKS = 4,
    parameter int PREAMBLE_LEN  = 8,
    parameter bit IDLE_LEVEL    = 1'b0,
    parameter bit POLARITY      = 1'b0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              serial_out,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);
    localparam int MAX_BITS = DATA_W > PREAMBLE_LEN ? DATA_W : PREAMBLE_LEN;
    localparam int BW       = $clog2(MAX_BITS);
    localparam int HW       = HALF_BIT_CLKS > 1 ? $clog2(HALF_BIT_CLKS) : 1;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, TRAIL} state_t;

    state_t            state, state_nx;
    logic [HW-1:0]     half_cnt, half_cnt_nx;
    logic [BW-1:0]     bit_cnt, bit_cnt_nx, seg_last;
    logic [DATA_W-1:0] shreg, shreg_nx, buf_q, buf_nx;
    logic              phase, phase_nx;
    logic              cur_last, cur_last_nx, buf_last, buf_last_nx, buf_full, buf_full_nx;
    logic              rdy_en, accept, half_end, bit_end, seg_end;
    logic              line_bit, line_nx, done_nx, under_nx;

    assign busy     = state != IDLE;
    assign s_tready = rdy_en && (state == IDLE ||
                      ((state == PREAMBLE || state == DATA) && !cur_last && !buf_full));
    assign accept   = s_tvalid && s_tready;
    assign half_end = half_cnt == HW'(HALF_BIT_CLKS - 1);
    assign bit_end  = phase && half_end;
    assign seg_last = state == PREAMBLE ? BW'(PREAMBLE_LEN - 1) :
                      state == DATA     ? BW'(DATA_W - 1) : BW'(1);
    assign seg_end  = bit_end && bit_cnt == seg_last;

    always_comb begin
        state_nx    = state;
        half_cnt_nx = half_cnt;
        phase_nx    = phase;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        cur_last_nx = cur_last;
        buf_nx      = buf_q;
        buf_last_nx = buf_last;
        buf_full_nx = buf_full;
        done_nx     = 1'b0;
        under_nx    = 1'b0;
        if (state != IDLE) begin
            half_cnt_nx = half_end ? '0 : half_cnt + 1'b1;
            phase_nx    = half_end ? !phase : phase;
            bit_cnt_nx  = seg_end ? '0 : bit_end ? bit_cnt + 1'b1 : bit_cnt;
        end
        if (accept && state != IDLE) begin
            buf_nx      = s_tdata;
            buf_last_nx = s_tlast;
            buf_full_nx = 1'b1;
        end
        if (state == IDLE && accept) begin
            state_nx    = PREAMBLE;
            shreg_nx    = s_tdata;
            cur_last_nx = s_tlast;
        end else if (state == PREAMBLE && seg_end) begin
            state_nx = DATA;
        end else if (state == DATA && bit_end) begin
            shreg_nx = shreg << 1;
            if (seg_end) begin
                if (cur_last) begin
                    state_nx = TRAIL;
                end else if (buf_full || accept) begin
                    // a word arriving on the boundary cycle bypasses the buffer
                    shreg_nx    = buf_full ? buf_q : s_tdata;
                    cur_last_nx = buf_full ? buf_last : s_tlast;
                    buf_full_nx = 1'b0;
                end else begin
                    under_nx = 1'b1;
                    state_nx = TRAIL;
                end
            end
        end else if (state == TRAIL && seg_end) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
        end
        line_bit = state_nx == PREAMBLE ? !bit_cnt_nx[0] : shreg_nx[DATA_W-1];
        line_nx  = (state_nx == PREAMBLE || state_nx == DATA) ?
                   ((phase_nx ? line_bit : !line_bit) ^ POLARITY) : IDLE_LEVEL;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            half_cnt   <= '0;
            phase      <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            cur_last   <= 1'b0;
            buf_q      <= '0;
            buf_last   <= 1'b0;
            buf_full   <= 1'b0;
            serial_out <= IDLE_LEVEL;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            rdy_en     <= 1'b0;
        end else begin
            state      <= state_nx;
            half_cnt   <= half_cnt_nx;
            phase      <= phase_nx;
            bit_cnt    <= bit_cnt_nx;
            shreg      <= shreg_nx;
            cur_last   <= cur_last_nx;
            buf_q      <= buf_nx;
            buf_last   <= buf_last_nx;
            buf_full   <= buf_full_nx;
            serial_out <= line_nx;
            frame_done <= done_nx;
            underrun   <= under_nx;
            rdy_en     <= 1'b1;
        end
    end
endmodule
